multi_ch_config: RTL and testbench
==================================

MULTI_CH_CONFIG -- requirements
Module: multi_ch_config

Interface
REQ-001 Parameters SHALL be:
- AW, default 12, per-channel length width.
- DW, default 32, data width.
- CW, default 6, config address width.
- NCH, default 4, channel count, 1..8.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- config_ena  in  1  write strobe.
- config_addr  in  CW  register address.
- config_wdata  in  DW  write data.
- config_rdata  out  DW  registered read data.
- task_start  out  NCH  per-channel one-cycle start pulse.
- param_raddr  out  NCH*DW  per-channel read address, channel c at bits [c*DW +: DW].
- param_waddr  out  NCH*DW  per-channel write address, same packing.
- param_iolen  out  NCH*AW  per-channel length, channel c at bits [c*AW +: AW].
- task_done  in  NCH  per-channel completion pulse.
- irq  out  1  level interrupt.

Function
REQ-003 Address map SHALL be:
- 4*c+0: RD_ADDR of channel c.
- 4*c+1: WR_ADDR of channel c.
- 4*c+2: IO_LEN of channel c. Writes take wdata[AW-1:0].
- 0x20: START, write-only bitmask.
- 0x21: STATE, read-only: {busy[NCH-1:0] at bits 15:8, done[NCH-1:0] at bits 7:0}.
- 0x22: DONE_CLR, write-1-to-clear done bits.
- 0x23: IRQ_EN, bits [NCH-1:0].
- 0x28+c: TIME of channel c, read-only.
- 0x3F: CHECK, reads 0xF0F0F0F0.
REQ-004 A parameter write to a busy channel SHALL be ignored; the register keeps its old value.
REQ-005 A START write with wdata[c]=1 to an idle channel c SHALL, in the next cycle:
- assert task_start[c] for exactly one cycle;
- set busy[c];
- clear done[c];
- zero time[c].
REQ-006 Start bits for busy channels, and bits at index NCH or above, SHALL be ignored.
REQ-007 One START write SHALL be able to launch several idle channels in the same cycle.
REQ-008 task_done[c] while busy[c] SHALL, next cycle, clear busy[c] and set done[c]; task_done[c] while idle SHALL be ignored.
REQ-009 Within a single cycle, task_done[c] SHALL take precedence over a START bit or a DONE_CLR bit for channel c.
REQ-010 time[c] SHALL increment by 1 on every cycle that busy[c] is high, saturate at 0xFFFFFFFF, and hold its value while idle.
REQ-011 irq SHALL be registered and SHALL equal OR-reduce(done & irq_en), one cycle after either operand changes.
REQ-012 Read behaviour SHALL be:
- config_rdata updates every cycle from config_addr with 1-cycle latency, independent of config_ena;
- unmapped addresses, and write-only START/DONE_CLR, read 0.
REQ-013 Every channel SHALL be independent; no channel's state may affect another's.

Reset
REQ-014 While rst=0, the following SHALL be 0 asynchronously:
- all parameter registers and the busy, done, time and irq_en state;
- task_start, irq and config_rdata.
REQ-015 Reset asserted mid-task SHALL abort the task with no task_start and no done; after release, a late task_done SHALL be ignored because the channel is idle.
REQ-016 The block SHALL leave reset on the first rising clk edge after rst rises.

Structure
REQ-017 Address constants and the CHECK value SHALL live in the shared package cfg_pkg, together with the helper functions ch_base(c) and time_addr(c).
REQ-018 Per-channel state (params, busy, done, time, start pulse) SHALL be one sub-module, cfg_channel, instantiated NCH times by generate; the top holds address decode, IRQ_EN, the irq register and the read mux.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write ch1 RD=0x1000, WR=0x2000, LEN=0x123; read 0x04/0x05/0x06 -> 0x1000/0x2000/0x123, each one cycle after the address is applied.
- START=0x5 -> task_start=0x5 for one cycle; STATE=0x0500. Pulse task_done[0] 10 cycles later -> STATE=0x0401, TIME ch0=10.
- With ch2 busy, write ch2 LEN=0x7 and START=0x4 -> LEN unchanged, no second task_start[2].
- IRQ_EN=0x2, finish ch1 -> irq=1. DONE_CLR=0x2 in the same cycle as a new task_done[1] -> done stays set; a later DONE_CLR=0x2 -> irq=0.
- Force time ch3 to 0xFFFFFFFE with ch3 busy -> reads 0xFFFFFFFF and then holds there.
- rst=0 while ch0 busy -> all outputs 0. After release, pulse task_done[0] -> STATE=0; read 0x3F -> 0xF0F0F0F0.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants for the multi-channel configuration block: register map,
// channel register offsets and address helpers.
package cfg_pkg;

    typedef enum logic [1:0] {
        REG_RD  = 2'd0,
        REG_WR  = 2'd1,
        REG_LEN = 2'd2
    } ch_reg_e;

    localparam int unsigned ADDR_START     = 32'h20;
    localparam int unsigned ADDR_STATE     = 32'h21;
    localparam int unsigned ADDR_DONE_CLR  = 32'h22;
    localparam int unsigned ADDR_IRQ_EN    = 32'h23;
    localparam int unsigned ADDR_TIME_BASE = 32'h28;
    localparam int unsigned ADDR_CHECK     = 32'h3F;
    localparam int unsigned CHECK_VALUE    = 32'hF0F0_F0F0;

    localparam int          TIME_W   = 32;
    localparam int unsigned TIME_MAX = 32'hFFFF_FFFF;

    function automatic int unsigned ch_base(input int unsigned c);
        return 32'd4 * c;
    endfunction

    function automatic int unsigned time_addr(input int unsigned c);
        return ADDR_TIME_BASE + c;
    endfunction

endpackage

// File: rtl/cfg_channel.sv
// One channel: parameter registers, busy/done status, busy-time counter and
// the one-cycle start pulse.
module cfg_channel
    import cfg_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     wdata,
    input  logic              wr_raddr,
    input  logic              wr_waddr,
    input  logic              wr_iolen,
    input  logic              start_req,
    input  logic              clr_req,
    input  logic              task_done,
    output logic [DW-1:0]     raddr,
    output logic [DW-1:0]     waddr,
    output logic [AW-1:0]     iolen,
    output logic              busy,
    output logic              done,
    output logic [TIME_W-1:0] time_val,
    output logic              task_start
);

    logic [DW-1:0]     raddr_q, raddr_d;
    logic [DW-1:0]     waddr_q, waddr_d;
    logic [AW-1:0]     iolen_q, iolen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              start_q, start_d;
    logic              done_evt_s;
    logic              launch_s;

    // Next-state: completion outranks start and clear; params frozen while busy.
    always_comb begin
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        iolen_d    = iolen_q;
        busy_d     = busy_q;
        done_d     = done_q;
        time_d     = time_q;
        done_evt_s = task_done && busy_q;
        launch_s   = start_req && !busy_q;
        start_d    = launch_s;

        if (wr_raddr && !busy_q) raddr_d = wdata;
        else                     raddr_d = raddr_q;
        if (wr_waddr && !busy_q) waddr_d = wdata;
        else                     waddr_d = waddr_q;
        if (wr_iolen && !busy_q) iolen_d = wdata[AW-1:0];
        else                     iolen_d = iolen_q;

        if (done_evt_s) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (launch_s) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (clr_req) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (launch_s)                                     time_d = '0;
        else if (busy_q && (time_q != TIME_W'(TIME_MAX))) time_d = time_q + 32'd1;
        else                                              time_d = time_q;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raddr_q <= '0;
            waddr_q <= '0;
            iolen_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            time_q  <= '0;
            start_q <= 1'b0;
        end else begin
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            iolen_q <= iolen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            time_q  <= time_d;
            start_q <= start_d;
        end
    end

    assign raddr      = raddr_q;
    assign waddr      = waddr_q;
    assign iolen      = iolen_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign time_val   = time_q;
    assign task_start = start_q;

endmodule

// File: rtl/multi_ch_config.sv
// Multi-channel task configuration block: register decode, per-channel
// instances, interrupt enable/line and the registered read mux.
module multi_ch_config
    import cfg_pkg::*;
#(
    parameter int AW  = 12,
    parameter int DW  = 32,
    parameter int CW  = 6,
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              config_ena,
    input  logic [CW-1:0]     config_addr,
    input  logic [DW-1:0]     config_wdata,
    output logic [DW-1:0]     config_rdata,
    output logic [NCH-1:0]    task_start,
    output logic [NCH*DW-1:0] param_raddr,
    output logic [NCH*DW-1:0] param_waddr,
    output logic [NCH*AW-1:0] param_iolen,
    input  logic [NCH-1:0]    task_done,
    output logic              irq
);

    logic [NCH-1:0]        wr_raddr_s, wr_waddr_s, wr_iolen_s;
    logic [NCH-1:0]        start_req_s, clr_req_s;
    logic [NCH-1:0]        busy_s, done_s;
    logic [NCH*TIME_W-1:0] time_all_s;
    logic [NCH-1:0]        irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic [DW-1:0]         ch_rd_s, ch_word_s, fixed_rd_s;
    logic [7:0]            busy8_s, done8_s;

    assign start_req_s = (config_ena && (config_addr == CW'(ADDR_START)))    ? config_wdata[NCH-1:0] : '0;
    assign clr_req_s   = (config_ena && (config_addr == CW'(ADDR_DONE_CLR))) ? config_wdata[NCH-1:0] : '0;

    for (genvar c = 0; c < NCH; c++) begin : gen_ch
        assign wr_raddr_s[c] = config_ena && (config_addr == CW'(ch_base(c) + 32'(REG_RD)));
        assign wr_waddr_s[c] = config_ena && (config_addr == CW'(ch_base(c) + 32'(REG_WR)));
        assign wr_iolen_s[c] = config_ena && (config_addr == CW'(ch_base(c) + 32'(REG_LEN)));

        cfg_channel #(.AW(AW), .DW(DW)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wdata      (config_wdata),
            .wr_raddr   (wr_raddr_s[c]),
            .wr_waddr   (wr_waddr_s[c]),
            .wr_iolen   (wr_iolen_s[c]),
            .start_req  (start_req_s[c]),
            .clr_req    (clr_req_s[c]),
            .task_done  (task_done[c]),
            .raddr      (param_raddr[c*DW +: DW]),
            .waddr      (param_waddr[c*DW +: DW]),
            .iolen      (param_iolen[c*AW +: AW]),
            .busy       (busy_s[c]),
            .done       (done_s[c]),
            .time_val   (time_all_s[c*TIME_W +: TIME_W]),
            .task_start (task_start[c])
        );
    end

    // Interrupt enable register and level interrupt from enabled done bits.
    always_comb begin
        if (config_ena && (config_addr == CW'(ADDR_IRQ_EN))) irq_en_d = config_wdata[NCH-1:0];
        else                                                  irq_en_d = irq_en_q;
        irq_d = |(done_s & irq_en_q);
    end

    // Read mux: channel windows OR-ed with the shared status registers.
    always_comb begin
        ch_rd_s   = '0;
        ch_word_s = '0;
        busy8_s   = 8'(busy_s);
        done8_s   = 8'(done_s);
        for (int c = 0; c < NCH; c++) begin
            if (config_addr == CW'(ch_base(c) + 32'(REG_RD)))       ch_word_s = param_raddr[c*DW +: DW];
            else if (config_addr == CW'(ch_base(c) + 32'(REG_WR)))  ch_word_s = param_waddr[c*DW +: DW];
            else if (config_addr == CW'(ch_base(c) + 32'(REG_LEN))) ch_word_s = DW'(param_iolen[c*AW +: AW]);
            else if (config_addr == CW'(time_addr(c)))              ch_word_s = DW'(time_all_s[c*TIME_W +: TIME_W]);
            else                                                    ch_word_s = '0;
            ch_rd_s = ch_rd_s | ch_word_s;
        end
        case (config_addr)
            CW'(ADDR_STATE):  fixed_rd_s = DW'({busy8_s, done8_s});
            CW'(ADDR_IRQ_EN): fixed_rd_s = DW'(irq_en_q);
            CW'(ADDR_CHECK):  fixed_rd_s = DW'(CHECK_VALUE);
            default:          fixed_rd_s = '0;
        endcase
        rdata_d = ch_rd_s | fixed_rd_s;
    end

    // Shared registers: interrupt enable, interrupt line, read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign irq          = irq_q;
    assign config_rdata = rdata_q;

endmodule

// File: tb/tb_multi_ch_config.sv
// Self-checking bench for multi_ch_config: a table of register writes/reads
// followed by directed multi-cycle sequences; reads are scoreboarded.
module tb_multi_ch_config;

    localparam int AW = 12, DW = 32, CW = 6, NCH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              config_ena = 1'b0;
    logic [CW-1:0]     config_addr = '0;
    logic [DW-1:0]     config_wdata = '0;
    logic [DW-1:0]     config_rdata;
    logic [NCH-1:0]    task_start;
    logic [NCH*DW-1:0] param_raddr, param_waddr;
    logic [NCH*AW-1:0] param_iolen;
    logic [NCH-1:0]    task_done = '0;
    logic              irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    multi_ch_config #(.AW(AW), .DW(DW), .CW(CW), .NCH(NCH)) dut (
        .clk          (clk),
        .rst          (rst),
        .config_ena   (config_ena),
        .config_addr  (config_addr),
        .config_wdata (config_wdata),
        .config_rdata (config_rdata),
        .task_start   (task_start),
        .param_raddr  (param_raddr),
        .param_waddr  (param_waddr),
        .param_iolen  (param_iolen),
        .task_done    (task_done),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        config_ena   = 1'b1;
        config_addr  = a;
        config_wdata = d;
        tick();
        config_ena   = 1'b0;
        config_wdata = '0;
    endtask

    task automatic rd(input string name, input logic [5:0] a, input logic [31:0] exp);
        exp_t e;
        config_addr = a;
        sb_q.push_back('{name, exp});
        tick();
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, config_rdata, e.exp);
        end
    endtask

    initial begin
        // Register table: writes and scoreboarded reads.
        vecs.push_back('{1'b1, 6'h04, 32'h0000_1000, 32'h0});
        vecs.push_back('{1'b1, 6'h05, 32'h0000_2000, 32'h0});
        vecs.push_back('{1'b1, 6'h06, 32'h0000_0123, 32'h0});
        vecs.push_back('{1'b0, 6'h04, 32'h0, 32'h0000_1000});
        vecs.push_back('{1'b0, 6'h05, 32'h0, 32'h0000_2000});
        vecs.push_back('{1'b0, 6'h06, 32'h0, 32'h0000_0123});
        vecs.push_back('{1'b1, 6'h02, 32'hFFFF_F456, 32'h0});
        vecs.push_back('{1'b0, 6'h02, 32'h0, 32'h0000_0456});
        vecs.push_back('{1'b1, 6'h00, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 6'h00, 32'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 6'h0C, 32'h0000_A5A5, 32'h0});
        vecs.push_back('{1'b0, 6'h0C, 32'h0, 32'h0000_A5A5});
        vecs.push_back('{1'b1, 6'h0A, 32'h0000_0055, 32'h0});
        vecs.push_back('{1'b0, 6'h0A, 32'h0, 32'h0000_0055});
        vecs.push_back('{1'b0, 6'h03, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 6'h07, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 6'h20, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 6'h22, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 6'h30, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 6'h3F, 32'h0, 32'hF0F0_F0F0});
        vecs.push_back('{1'b1, 6'h23, 32'h0000_00FF, 32'h0});
        vecs.push_back('{1'b0, 6'h23, 32'h0, 32'h0000_000F});
        vecs.push_back('{1'b1, 6'h23, 32'h0000_0000, 32'h0});
        vecs.push_back('{1'b0, 6'h23, 32'h0, 32'h0});

        // Reset state, then release mid-cycle with CHECK already addressed.
        config_addr = 6'h3F;
        #2;
        chk("rst_rdata", config_rdata, 32'h0);
        chk("rst_start", 32'(task_start), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_params", 32'(|{param_raddr, param_waddr, param_iolen}), 32'h0);
        #10;
        rst = 1'b1;
        tick();
        chk("first_edge_check", config_rdata, 32'hF0F0_F0F0);
        rd("rst_state", 6'h21, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            else rd($sformatf("vec%0d_a%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end
        chk("port_raddr1", param_raddr[1*DW +: DW], 32'h0000_1000);
        chk("port_waddr1", param_waddr[1*DW +: DW], 32'h0000_2000);
        chk("port_iolen0", 32'(param_iolen[0 +: AW]), 32'h0000_0456);

        // Start bits above NCH do nothing.
        wr(6'h20, 32'h0000_00F0);
        chk("start_hi_bits", 32'(task_start), 32'h0);
        rd("state_hi_bits", 6'h21, 32'h0);

        // Launch ch0+ch2; finish ch0 ten busy cycles later.
        wr(6'h20, 32'h0000_0005);
        chk("start_pulse", 32'(task_start), 32'h5);
        rd("state_busy", 6'h21, 32'h0000_0500);
        chk("start_pulse_end", 32'(task_start), 32'h0);
        repeat (8) tick();
        task_done   = 4'h1;
        config_addr = 6'h21;
        tick();
        task_done = 4'h0;
        rd("state_done0", 6'h21, 32'h0000_0401);
        rd("time0", 6'h28, 32'd10);

        // Busy ch2 ignores parameter writes and restarts; ch0 stays writable.
        wr(6'h0A, 32'h0000_0007);
        rd("len2_locked", 6'h0A, 32'h0000_0055);
        wr(6'h20, 32'h0000_0004);
        chk("no_restart2", 32'(task_start), 32'h0);
        chk("port_iolen2", 32'(param_iolen[2*AW +: AW]), 32'h0000_0055);
        wr(6'h01, 32'h0000_3333);
        rd("wr0_indep", 6'h01, 32'h0000_3333);

        // Interrupt on ch1, done beats a same-cycle DONE_CLR.
        wr(6'h23, 32'h0000_0002);
        chk("irq_off", 32'(irq), 32'h0);
        wr(6'h20, 32'h0000_0002);
        task_done = 4'h2;
        tick();
        task_done = 4'h0;
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_on", 32'(irq), 32'h1);
        wr(6'h20, 32'h0000_0002);
        config_ena   = 1'b1;
        config_addr  = 6'h22;
        config_wdata = 32'h0000_0002;
        task_done    = 4'h2;
        tick();
        config_ena   = 1'b0;
        config_wdata = '0;
        task_done    = 4'h0;
        tick();
        chk("irq_done_wins", 32'(irq), 32'h1);
        rd("state_done01", 6'h21, 32'h0000_0403);
        wr(6'h22, 32'h0000_0002);
        tick();
        chk("irq_cleared", 32'(irq), 32'h0);

        // Saturating busy timer on ch3.
        wr(6'h20, 32'h0000_0008);
        force dut.gen_ch[3].u_ch.time_q = 32'hFFFF_FFFE;
        tick();
        release dut.gen_ch[3].u_ch.time_q;
        tick();
        rd("time3_sat", 6'h2B, 32'hFFFF_FFFF);
        rd("time3_hold", 6'h2B, 32'hFFFF_FFFF);

        // Reset during a ch0 task, then a stale completion.
        wr(6'h20, 32'h0000_0001);
        chk("start0_again", 32'(task_start), 32'h1);
        config_addr = 6'h3F;
        tick();
        chk("pre_rst_rdata", config_rdata, 32'hF0F0_F0F0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdata", config_rdata, 32'h0);
        chk("mid_rst_start", 32'(task_start), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_params", 32'(|{param_raddr, param_waddr, param_iolen}), 32'h0);
        #3;
        rst = 1'b1;
        tick();
        task_done = 4'h1;
        tick();
        task_done = 4'h0;
        chk("late_done_start", 32'(task_start), 32'h0);
        rd("post_rst_state", 6'h21, 32'h0);
        rd("post_rst_irqen", 6'h23, 32'h0);
        rd("post_rst_rd1", 6'h04, 32'h0);
        rd("post_rst_time0", 6'h28, 32'h0);
        rd("post_rst_check", 6'h3F, 32'hF0F0_F0F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
